// File: rtl/delay_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : delay_port_arbiter
// Description : Round-robin arbiter sharing the delay_master request port
//               among n_req requesters, one transaction in flight at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module delay_port_arbiter #(
    parameter int data_width = 16,
    parameter int n_req      = 4,
    parameter int timeout    = 255
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [n_req-1:0]              rd_req,
    input  logic [n_req-1:0]              wr_req,
    input  logic [n_req*data_width-1:0]   req_handle,
    input  logic [n_req*data_width-1:0]   req_wr_data,
    input  logic [n_req*data_width-1:0]   req_wr_inc,
    output logic [n_req-1:0]              rd_ack,
    output logic [n_req-1:0]              wr_ack,
    output logic [data_width-1:0]         rd_data,
    output logic                          mem_read_req,
    output logic                          mem_write_req,
    output logic [data_width-1:0]         mem_handle,
    output logic [data_width-1:0]         mem_write_data,
    output logic [data_width-1:0]         mem_write_inc,
    input  logic [data_width-1:0]         mem_read_data,
    input  logic                          mem_read_valid,
    input  logic                          mem_write_ack,
    output logic                          busy,
    output logic                          error,
    input  logic                          clear_error
);

    localparam int                 c_idx_w    = $clog2(n_req);
    localparam logic [c_idx_w-1:0] c_last_rst = c_idx_w'(n_req - 1);
    localparam logic [7:0]         c_timeout  = 8'(timeout);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t             r_state;
    logic [c_idx_w-1:0] r_last;
    logic [c_idx_w-1:0] r_idx;
    logic               r_op_wr;
    logic [7:0]         r_count;
    logic [n_req-1:0]   r_rd_mask;
    logic [n_req-1:0]   r_wr_mask;

    logic [n_req-1:0]   w_rd_pend;
    logic [n_req-1:0]   w_wr_pend;
    logic               w_found;
    logic               w_win_rd;
    logic [c_idx_w-1:0] w_win;
    int                 w_best;
    logic               w_done;

    // Winner is the pending requester at the smallest rotational distance past r_last.
    always_comb begin
        w_rd_pend = rd_req & ~r_rd_mask;
        w_wr_pend = wr_req & ~r_wr_mask;
        w_found   = 1'b0;
        w_win     = '0;
        w_win_rd  = 1'b0;
        w_best    = n_req;
        for (int i = 0; i < n_req; i++) begin
            if ((w_rd_pend[i] || w_wr_pend[i]) &&
                (((i + 2*n_req - int'(r_last) - 1) % n_req) < w_best)) begin
                w_best   = (i + 2*n_req - int'(r_last) - 1) % n_req;
                w_found  = 1'b1;
                w_win    = c_idx_w'(i);
                w_win_rd = w_rd_pend[i];
            end
        end
    end

    assign w_done = r_op_wr ? mem_write_ack : mem_read_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= ST_IDLE;
            r_last         <= c_last_rst;
            r_idx          <= '0;
            r_op_wr        <= 1'b0;
            r_count        <= '0;
            r_rd_mask      <= '0;
            r_wr_mask      <= '0;
            rd_ack         <= '0;
            wr_ack         <= '0;
            rd_data        <= '0;
            mem_read_req   <= 1'b0;
            mem_write_req  <= 1'b0;
            mem_handle     <= '0;
            mem_write_data <= '0;
            mem_write_inc  <= '0;
            busy           <= 1'b0;
            error          <= 1'b0;
        end else begin
            rd_ack        <= '0;
            wr_ack        <= '0;
            mem_read_req  <= 1'b0;
            mem_write_req <= 1'b0;
            r_rd_mask     <= '0;
            r_wr_mask     <= '0;
            // A timeout later in this block overrides the clear.
            if (clear_error) begin
                error <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_idx          <= w_win;
                        r_last         <= w_win;
                        r_op_wr        <= !w_win_rd;
                        mem_handle     <= req_handle[int'(w_win)*data_width +: data_width];
                        mem_write_data <= req_wr_data[int'(w_win)*data_width +: data_width];
                        mem_write_inc  <= req_wr_inc[int'(w_win)*data_width +: data_width];
                        mem_read_req   <= w_win_rd;
                        mem_write_req  <= !w_win_rd;
                        busy           <= 1'b1;
                        r_state        <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_count <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (w_done || (r_count == c_timeout)) begin
                        if (r_op_wr) begin
                            wr_ack[r_idx]    <= 1'b1;
                            r_wr_mask[r_idx] <= 1'b1;
                        end else begin
                            rd_ack[r_idx]    <= 1'b1;
                            r_rd_mask[r_idx] <= 1'b1;
                        end
                        if (!w_done) begin
                            rd_data <= '0;
                            error   <= 1'b1;
                        end else if (!r_op_wr) begin
                            rd_data <= mem_read_data;
                        end
                        busy    <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_count <= r_count + 8'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_delay_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_delay_port_arbiter
// Description : Directed and randomized bench for delay_port_arbiter with a
//               transaction-level round-robin reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_delay_port_arbiter;

    localparam int DW = 16;
    localparam int NR = 4;
    localparam int TO = 8;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [NR-1:0]    rd_req, wr_req;
    logic [NR*DW-1:0] req_handle, req_wr_data, req_wr_inc;
    logic [NR-1:0]    rd_ack, wr_ack;
    logic [DW-1:0]    rd_data;
    logic             mem_read_req, mem_write_req;
    logic [DW-1:0]    mem_handle, mem_write_data, mem_write_inc;
    logic [DW-1:0]    mem_read_data;
    logic             mem_read_valid, mem_write_ack;
    logic             busy, error, clear_error;

    int checks = 0;
    int errors = 0;
    int n_rd_p = 0;
    int n_wr_p = 0;

    // Reference model: outstanding requests, fields, and last granted index.
    logic [NR-1:0] m_rp, m_wp, held_rd, held_wr;
    logic [DW-1:0] m_h [NR];
    logic [DW-1:0] m_d [NR];
    logic [DW-1:0] m_i [NR];
    int            m_last;

    delay_port_arbiter #(.data_width(DW), .n_req(NR), .timeout(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .rd_req(rd_req), .wr_req(wr_req),
        .req_handle(req_handle), .req_wr_data(req_wr_data), .req_wr_inc(req_wr_inc),
        .rd_ack(rd_ack), .wr_ack(wr_ack), .rd_data(rd_data),
        .mem_read_req(mem_read_req), .mem_write_req(mem_write_req),
        .mem_handle(mem_handle), .mem_write_data(mem_write_data), .mem_write_inc(mem_write_inc),
        .mem_read_data(mem_read_data), .mem_read_valid(mem_read_valid), .mem_write_ack(mem_write_ack),
        .busy(busy), .error(error), .clear_error(clear_error)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            if (mem_read_req === 1'b1)  n_rd_p++;
            if (mem_write_req === 1'b1) n_wr_p++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    task automatic apply_reqs();
        for (int i = 0; i < NR; i++) begin
            rd_req[i]                = m_rp[i] | held_rd[i];
            wr_req[i]                = m_wp[i] | held_wr[i];
            req_handle[i*DW +: DW]   = m_h[i];
            req_wr_data[i*DW +: DW]  = m_d[i];
            req_wr_inc[i*DW +: DW]   = m_i[i];
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        m_rp = '0; m_wp = '0; held_rd = '0; held_wr = '0;
        for (int i = 0; i < NR; i++) begin
            m_h[i] = '0; m_d[i] = '0; m_i[i] = '0;
        end
        mem_read_valid = 1'b0; mem_write_ack = 1'b0; mem_read_data = '0; clear_error = 1'b0;
        apply_reqs();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        m_last = NR - 1;
    endtask

    // Round-robin rule: first requester with an outstanding request after m_last.
    function automatic int model_pick();
        for (int off = 1; off <= NR; off++) begin
            if (m_rp[(m_last + off) % NR] || m_wp[(m_last + off) % NR]) return (m_last + off) % NR;
        end
        return -1;
    endfunction

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (rd_ack !== '0 || wr_ack !== '0) begin errors++; $display("FAIL reset_acks: got %b/%b want 0/0", rd_ack, wr_ack); end
        checks++; if (rd_data !== '0) begin errors++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
        checks++; if (mem_read_req !== 1'b0 || mem_write_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b%b want 00", mem_read_req, mem_write_req); end
        checks++; if (mem_handle !== '0 || mem_write_data !== '0 || mem_write_inc !== '0) begin errors++; $display("FAIL reset_latches: got %h %h %h want 0 0 0", mem_handle, mem_write_data, mem_write_inc); end
        checks++; if (busy !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL reset_busy_error: got %b%b want 00", busy, error); end
    endtask

    task automatic test_single_read();
        int br;
        br = n_rd_p;
        m_h[2] = 16'h0005; m_rp[2] = 1'b1; apply_reqs();
        @(negedge clk);
        checks++; if (mem_read_req !== 1'b1 || mem_write_req !== 1'b0) begin errors++; $display("FAIL single_pulse: got %b%b want 10", mem_read_req, mem_write_req); end
        checks++; if (mem_handle !== 16'h0005) begin errors++; $display("FAIL single_handle: got %h want 0005", mem_handle); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
        @(negedge clk);
        checks++; if (mem_read_req !== 1'b0) begin errors++; $display("FAIL single_pulse_len: got %b want 0", mem_read_req); end
        @(negedge clk);
        mem_read_valid = 1'b1; mem_read_data = 16'h1234;
        checks++; if (rd_ack !== '0) begin errors++; $display("FAIL single_early_ack: got %b want 0000", rd_ack); end
        @(negedge clk);
        mem_read_valid = 1'b0; mem_read_data = '0;
        checks++; if (rd_ack !== 4'b0100 || wr_ack !== '0) begin errors++; $display("FAIL single_ack: got %b/%b want 0100/0000", rd_ack, wr_ack); end
        checks++; if (rd_data !== 16'h1234) begin errors++; $display("FAIL single_rd_data: got %h want 1234", rd_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_low: got %b want 0", busy); end
        @(negedge clk);
        m_rp[2] = 1'b0; apply_reqs();
        checks++; if (rd_ack !== '0) begin errors++; $display("FAIL single_ack_len: got %b want 0000", rd_ack); end
        checks++; if (n_rd_p - br !== 1) begin errors++; $display("FAIL single_pulse_count: got %0d want 1", n_rd_p - br); end
    endtask

    task automatic test_held_request();
        int br;
        br = n_rd_p;
        m_h[0] = 16'h0044; m_rp[0] = 1'b1; apply_reqs();
        @(negedge clk);
        checks++; if (mem_read_req !== 1'b1 || mem_handle !== 16'h0044) begin errors++; $display("FAIL held_pulse: got %b %h want 1 0044", mem_read_req, mem_handle); end
        @(negedge clk);
        mem_read_valid = 1'b1; mem_read_data = 16'h5555;
        @(negedge clk);
        mem_read_valid = 1'b0;
        checks++; if (rd_ack !== 4'b0001 || rd_data !== 16'h5555) begin errors++; $display("FAIL held_ack: got %b %h want 0001 5555", rd_ack, rd_data); end
        @(negedge clk);
        checks++; if (mem_read_req !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL held_regrant: got req %b busy %b want 0 0", mem_read_req, busy); end
        m_rp[0] = 1'b0; apply_reqs();
        @(negedge clk);
        checks++; if (n_rd_p - br !== 1 || busy !== 1'b0) begin errors++; $display("FAIL held_count: got %0d busy %b want 1 0", n_rd_p - br, busy); end
    endtask

    task automatic test_round_robin();
        int bw, e_idx;
        logic [NR-1:0] ev;
        do_reset();
        for (int i = 0; i < NR; i++) begin
            m_wp[i] = 1'b1; m_h[i] = 16'h0100 + 16'(i); m_d[i] = 16'h0200 + 16'(i); m_i[i] = 16'h0001;
        end
        apply_reqs();
        bw = n_wr_p;
        for (int k = 0; k < 5; k++) begin
            e_idx = k % NR;
            @(negedge clk);
            checks++; if (mem_write_req !== 1'b1 || mem_read_req !== 1'b0 || mem_handle !== m_h[e_idx] || mem_write_data !== m_d[e_idx])
                begin errors++; $display("FAIL rr_grant%0d: got %b%b h=%h d=%h want 01 h=%h d=%h", k, mem_read_req, mem_write_req, mem_handle, mem_write_data, m_h[e_idx], m_d[e_idx]); end
            @(negedge clk);
            mem_write_ack = 1'b1;
            @(negedge clk);
            mem_write_ack = 1'b0;
            ev = '0; ev[e_idx] = 1'b1;
            checks++; if (wr_ack !== ev || rd_ack !== '0) begin errors++; $display("FAIL rr_ack%0d: got %b/%b want %b/0000", k, wr_ack, rd_ack, ev); end
            if (k == 4) begin m_wp = '0; apply_reqs(); end
        end
        repeat (2) @(negedge clk);
        checks++; if (n_wr_p - bw !== 5 || busy !== 1'b0) begin errors++; $display("FAIL rr_count: got %0d busy %b want 5 0", n_wr_p - bw, busy); end
    endtask

    task automatic test_rd_wr_same();
        int br, bw;
        br = n_rd_p; bw = n_wr_p;
        m_rp[1] = 1'b1; m_wp[1] = 1'b1; m_h[1] = 16'h0033; m_d[1] = 16'h00AA; m_i[1] = 16'h0001; apply_reqs();
        @(negedge clk);
        checks++; if (mem_read_req !== 1'b1 || mem_write_req !== 1'b0 || mem_handle !== 16'h0033) begin errors++; $display("FAIL rw_read_first: got %b%b %h want 10 0033", mem_read_req, mem_write_req, mem_handle); end
        @(negedge clk);
        mem_read_valid = 1'b1; mem_read_data = 16'h0F0F;
        @(negedge clk);
        mem_read_valid = 1'b0;
        checks++; if (rd_ack !== 4'b0010 || wr_ack !== '0 || rd_data !== 16'h0F0F) begin errors++; $display("FAIL rw_read_ack: got %b/%b %h want 0010/0000 0f0f", rd_ack, wr_ack, rd_data); end
        @(negedge clk);
        m_rp[1] = 1'b0; apply_reqs();
        checks++; if (mem_write_req !== 1'b1 || mem_read_req !== 1'b0 || mem_write_data !== 16'h00AA || mem_write_inc !== 16'h0001 || mem_handle !== 16'h0033)
            begin errors++; $display("FAIL rw_write_issue: got %b%b d=%h i=%h h=%h want 01 00aa 0001 0033", mem_read_req, mem_write_req, mem_write_data, mem_write_inc, mem_handle); end
        @(negedge clk);
        mem_write_ack = 1'b1;
        @(negedge clk);
        mem_write_ack = 1'b0;
        checks++; if (wr_ack !== 4'b0010 || rd_ack !== '0) begin errors++; $display("FAIL rw_write_ack: got %b/%b want 0010/0000", wr_ack, rd_ack); end
        @(negedge clk);
        m_wp[1] = 1'b0; apply_reqs();
        @(negedge clk);
        checks++; if (n_rd_p - br !== 1 || n_wr_p - bw !== 1 || busy !== 1'b0) begin errors++; $display("FAIL rw_count: got rd %0d wr %0d busy %b want 1 1 0", n_rd_p - br, n_wr_p - bw, busy); end
    endtask

    task automatic test_timeout();
        bit early;
        early = 1'b0;
        m_rp[3] = 1'b1; m_h[3] = 16'h0077; apply_reqs();
        @(negedge clk);
        checks++; if (mem_read_req !== 1'b1) begin errors++; $display("FAIL to_pulse: got %b want 1", mem_read_req); end
        for (int c = 2; c <= 10; c++) begin
            @(negedge clk);
            if (rd_ack !== '0 || wr_ack !== '0) early = 1'b1;
            mem_write_ack = (c == 4 || c == 5);
            clear_error   = (c == 10);
        end
        @(negedge clk);
        clear_error = 1'b0; mem_write_ack = 1'b0;
        checks++; if (early) begin errors++; $display("FAIL to_early_ack: got early ack want none before 9th WAIT edge"); end
        checks++; if (rd_ack !== 4'b1000 || wr_ack !== '0) begin errors++; $display("FAIL to_ack: got %b/%b want 1000/0000", rd_ack, wr_ack); end
        checks++; if (rd_data !== '0) begin errors++; $display("FAIL to_rd_data: got %h want 0000", rd_data); end
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL to_error_set_wins: got %b want 1", error); end
        @(negedge clk);
        m_rp[3] = 1'b0; apply_reqs();
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL to_error_sticky: got %b want 1", error); end
        clear_error = 1'b1;
        @(negedge clk);
        clear_error = 1'b0;
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL to_error_clear: got %b want 0", error); end
    endtask

    task automatic test_reset_mid_wait();
        m_rp[2] = 1'b1; m_h[2] = 16'h0022; apply_reqs();
        @(negedge clk);
        checks++; if (mem_read_req !== 1'b1 || mem_handle !== 16'h0022) begin errors++; $display("FAIL rst_pulse: got %b %h want 1 0022", mem_read_req, mem_handle); end
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        m_rp[2] = 1'b0; apply_reqs();
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_async_busy: got %b want 0", busy); end
        @(negedge clk);
        checks++; if (rd_ack !== '0 || mem_read_req !== 1'b0 || mem_handle !== '0 || rd_data !== '0 || error !== 1'b0)
            begin errors++; $display("FAIL rst_outputs: got ack %b req %b h %h d %h err %b want 0", rd_ack, mem_read_req, mem_handle, rd_data, error); end
        reset_n = 1'b1;
        m_last = NR - 1;
        m_rp[0] = 1'b1; m_h[0] = 16'h00A0; m_rp[3] = 1'b1; m_h[3] = 16'h00A3; apply_reqs();
        mem_read_valid = 1'b1; mem_read_data = 16'hDEAD;
        @(negedge clk);
        mem_read_valid = 1'b0;
        checks++; if (rd_ack !== '0 || wr_ack !== '0) begin errors++; $display("FAIL rst_late_ack: got %b/%b want 0000/0000", rd_ack, wr_ack); end
        checks++; if (mem_read_req !== 1'b1 || mem_handle !== 16'h00A0) begin errors++; $display("FAIL rst_first_grant: got %b %h want 1 00a0", mem_read_req, mem_handle); end
    endtask

    task automatic test_random();
        int prev_idx, win, lat, tx, bp, j;
        bit have_prev, win_rd, early;
        logic [DW-1:0] rdat;
        logic [NR-1:0] exp_rd, exp_wr;
        do_reset();
        have_prev = 1'b0; prev_idx = 0; tx = 0;
        bp = n_rd_p + n_wr_p;
        for (int t = 0; t < 60; t++) begin
            if (t < 40) begin
                for (int i = 0; i < NR; i++) begin
                    if (!m_rp[i] && !m_wp[i] && !(have_prev && i == prev_idx) && $urandom_range(0, 1) == 1) begin
                        m_rp[i] = 1'($urandom_range(0, 1));
                        m_wp[i] = !m_rp[i] || ($urandom_range(0, 1) == 1);
                        m_h[i] = DW'($urandom); m_d[i] = DW'($urandom); m_i[i] = DW'($urandom);
                    end
                end
            end
            win = model_pick();
            if (win < 0) begin
                if (t >= 40) break;
                j = have_prev ? (prev_idx + 1) % NR : 0;
                m_rp[j] = 1'b1; m_h[j] = DW'($urandom);
                win = model_pick();
            end
            win_rd = m_rp[win];
            apply_reqs();
            @(negedge clk);
            held_rd = '0; held_wr = '0; apply_reqs();
            tx++;
            checks++; if (mem_read_req !== win_rd || mem_write_req !== !win_rd || mem_handle !== m_h[win])
                begin errors++; $display("FAIL rnd_grant%0d: got %b%b h=%h want %b%b h=%h (req %0d)", t, mem_read_req, mem_write_req, mem_handle, win_rd, !win_rd, m_h[win], win); end
            if (!win_rd) begin
                checks++; if (mem_write_data !== m_d[win] || mem_write_inc !== m_i[win])
                    begin errors++; $display("FAIL rnd_wfields%0d: got %h %h want %h %h", t, mem_write_data, mem_write_inc, m_d[win], m_i[win]); end
            end
            lat = $urandom_range(1, 4);
            rdat = DW'($urandom);
            // Completion during the issue cycle must be ignored.
            if (win_rd) mem_read_valid = 1'($urandom_range(0, 1)); else mem_write_ack = 1'($urandom_range(0, 1));
            early = 1'b0;
            for (int c = 1; c <= lat; c++) begin
                @(negedge clk);
                if (rd_ack !== '0 || wr_ack !== '0) early = 1'b1;
                if (win_rd) begin
                    mem_write_ack  = 1'($urandom_range(0, 1));
                    mem_read_valid = (c == lat);
                    mem_read_data  = (c == lat) ? rdat : DW'($urandom);
                end else begin
                    mem_read_valid = 1'($urandom_range(0, 1));
                    mem_read_data  = DW'($urandom);
                    mem_write_ack  = (c == lat);
                end
            end
            @(negedge clk);
            mem_read_valid = 1'b0; mem_write_ack = 1'b0;
            checks++; if (early) begin errors++; $display("FAIL rnd_early%0d: got early ack want none (lat %0d)", t, lat); end
            exp_rd = '0; exp_wr = '0;
            if (win_rd) exp_rd[win] = 1'b1; else exp_wr[win] = 1'b1;
            checks++; if (rd_ack !== exp_rd || wr_ack !== exp_wr || busy !== 1'b0)
                begin errors++; $display("FAIL rnd_ack%0d: got %b/%b busy %b want %b/%b busy 0", t, rd_ack, wr_ack, busy, exp_rd, exp_wr); end
            if (win_rd) begin
                checks++; if (rd_data !== rdat) begin errors++; $display("FAIL rnd_rdata%0d: got %h want %h", t, rd_data, rdat); end
                m_rp[win] = 1'b0; held_rd[win] = 1'b1;
            end else begin
                m_wp[win] = 1'b0; held_wr[win] = 1'b1;
            end
            m_last = win; prev_idx = win; have_prev = 1'b1;
        end
        @(negedge clk);
        held_rd = '0; held_wr = '0; apply_reqs();
        repeat (3) @(negedge clk);
        checks++; if ((n_rd_p + n_wr_p - bp) !== tx || busy !== 1'b0)
            begin errors++; $display("FAIL rnd_total: got %0d pulses busy %b want %0d busy 0", n_rd_p + n_wr_p - bp, busy, tx); end
    endtask

    initial begin
        rd_req = '0; wr_req = '0; req_handle = '0; req_wr_data = '0; req_wr_inc = '0;
        mem_read_data = '0; mem_read_valid = 1'b0; mem_write_ack = 1'b0; clear_error = 1'b0;
        test_reset();
        test_single_read();
        test_held_request();
        test_round_robin();
        test_rd_wr_same();
        test_timeout();
        test_reset_mid_wait();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/delay_port_arbiter.md
# delay_port_arbiter

Round-robin arbiter sharing the single read/write request port of `delay_master` between up to `n_req` requesters (the `dsp_core` plus auxiliary engines). It keeps exactly one delay-memory transaction in flight. It routes the completion pulse and read data back to the granting requester. A timeout converts a hung transaction into a zero-data completion and raises a sticky error.

## Interface

**Parameters**
- `data_width`, 16, sample/handle/data width.
- `n_req`, 4, number of requesters (2..8).
- `timeout`, 255, cycles allowed in WAIT before forced completion (1..255).

**Ports**
- `clk`  in  1  clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `rd_req`  in  n_req  per-requester read request, level.
- `wr_req`  in  n_req  per-requester write request, level.
- `req_handle`  in  n_req*data_width  packed buffer handles, requester i at `[i*data_width +: data_width]`.
- `req_wr_data`  in  n_req*data_width  packed write samples.
- `req_wr_inc`  in  n_req*data_width  packed write-pointer increments.
- `rd_ack`  out  n_req  one-cycle read completion per requester.
- `wr_ack`  out  n_req  one-cycle write completion per requester.
- `rd_data`  out  data_width  read result, valid while any `rd_ack` bit is high.
- `mem_read_req`  out  1  one-cycle pulse to `delay_master.read_req`.
- `mem_write_req`  out  1  one-cycle pulse to `delay_master.write_req`.
- `mem_handle`  out  data_width  latched handle.
- `mem_write_data`  out  data_width  latched write sample.
- `mem_write_inc`  out  data_width  latched increment.
- `mem_read_data`  in  data_width  `delay_master.data_out`.
- `mem_read_valid`  in  1  read completion.
- `mem_write_ack`  in  1  write completion.
- `busy`  out  1  high in ISSUE/WAIT.
- `error`  out  1  sticky timeout flag.
- `clear_error`  in  1  synchronous clear of `error`.

## Operation

**Requester rules**
- A requester raises `rd_req`/`wr_req` and holds the request and its fields stable until the matching ack.
- It drops the request on the first edge after seeing the ack.
- Both bits high is legal. The read is served first, then the write, as two transactions.

**States**
- IDLE → ISSUE → WAIT → IDLE.
- **IDLE:** request vector = `{rd_req & ~rd_mask, wr_req & ~wr_mask}`.
  - If it is nonzero, select the first requester with any unmasked request, searching from `last+1` modulo `n_req`.
  - For that requester, read beats write.
  - Latch index, op, handle, data and inc. Set `last` := winner. Go to ISSUE.
- **ISSUE:** drive exactly one of `mem_read_req`/`mem_write_req` high for this one cycle, clear the timeout counter, go to WAIT.
- **WAIT:** count cycles.
  - Completion for a read op is `mem_read_valid`; for a write op it is `mem_write_ack`. The other completion input is ignored.
  - On completion, assert that requester's ack for one cycle. For a read, register `rd_data` := `mem_read_data`. Go to IDLE.
  - If the counter reaches `timeout` first, assert the ack with `rd_data` = 0, set `error`, and go to IDLE.
- **Masks:** on the edge an ack is asserted, set the mask bit for that (requester, op) only. Clear all masks on the following edge. This prevents re-granting a request that is still held during the ack cycle.
- **`error`:** a set in the same cycle as `clear_error` wins.

**Reset values** (`reset_n` low): state IDLE, `last` = n_req-1 (requester 0 first), all acks 0, `rd_data` 0, mem req pulses 0, mem latches 0, `busy` 0, `error` 0, masks 0. Reset mid-transaction abandons it with no ack. A completion pulse arriving afterwards in IDLE is ignored.

## Timing

- Request seen at edge E0 (IDLE):
  - `mem_*_req` high in cycle E0..E1 (ISSUE).
  - Completion sampled at edge Ek (k≥2).
  - Ack high in cycle Ek..Ek+1.
  - Next grant edge is Ek+1; the next mem pulse is at Ek+1..Ek+2.
- Minimum transaction: 3 cycles request-to-ack with a 1-cycle-latency memory. Back-to-back throughput is one transaction per 3 cycles.
- `busy` is registered: high from E0+ until the edge that asserts the ack.
- Fairness: any continuously asserted request is granted within `n_req` transactions.
- A completion pulse arriving in the ISSUE cycle is ignored. `delay_master` completes no earlier than one cycle after the request.
- Timeout: forced ack asserted `timeout`+1 edges after entering WAIT.

## Test plan

- **Single read:** requester 2 reads handle 0x0005; memory returns 0x1234 two cycles after `mem_read_req`. Required: one `mem_read_req` pulse with `mem_handle`=0x0005, then `rd_ack[2]` for one cycle with `rd_data`=0x1234, then `busy` low.
- **Round-robin:** all four requesters hold `wr_req` from reset. Required: grant order 0,1,2,3,0. Exactly one `mem_write_req` per transaction. No requester acked twice before the others are served.
- **Read+write same requester:** requester 1 asserts `rd_req` and `wr_req` together with write data 0x00AA and inc 1. Required: read is acked first. Write is issued on the next grant with `mem_write_data`=0x00AA. Exactly two transactions.
- **Held request during ack:** requester 0 drops `rd_req` one cycle after `rd_ack`. Required: no second `mem_read_req` for it; state stays IDLE.
- **Timeout:** `timeout`=8, memory never completes. Required: `rd_ack` on the 9th edge in WAIT, `rd_data`=0, `error`=1. `error` stays set until `clear_error` pulses.
- **Reset mid-WAIT:** `reset_n` pulsed low while in WAIT, and a late `mem_read_valid` arrives afterward. Required: all outputs at reset values, no ack, and the first post-reset grant goes to requester 0.
